// File: rtl/fb_rect_writer_if.sv
// Command handshake and frame-buffer write port of the rectangle fill engine.
// The engine takes the slave modport; the command source / buffer arbiter side takes master.
interface fb_rect_writer_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [9:0]         cmd_x;
  logic [9:0]         cmd_y;
  logic [9:0]         cmd_w;
  logic [9:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               fb_stall;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    input  cmd_ready, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    output cmd_ready, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/fb_rect_writer.sv
// Fills a clipped rectangle of the 4-bit palette frame buffer, one stallable
// write per pixel in raster order.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | clipped bounds known; decide empty vs. fill, load row/column counters
// FILL  | one write request per cycle, held while fb_stall
// DONE  | one-cycle completion pulse
module fb_rect_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  fb_rect_writer_if.slave  bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t state, state_nxt;

  logic [9:0]         x0, y0, cx, cy;
  logic [10:0]        x_end, y_end;
  logic [ADDR_W-1:0]  row_base, addr_q;
  logic [COLOR_W-1:0] color_q;

  logic [10:0]        x_sum, y_sum;
  logic               empty, wr_done, row_end, last_px;
  logic [ADDR_W-1:0]  row_base_init;

  assign x_sum   = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
  assign y_sum   = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
  assign empty   = ({1'b0, x0} >= x_end) || ({1'b0, y0} >= y_end);
  assign wr_done = (state == FILL) && !bus.fb_stall;
  assign row_end = ({1'b0, cx} + 11'd1) == x_end;
  assign last_px = row_end && (({1'b0, cy} + 11'd1) == y_end);
  assign row_base_init = ADDR_W'(y0) * ADDR_W'(H_RES);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = empty ? DONE : FILL;
      FILL:    if (wr_done && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x0       <= '0;
      y0       <= '0;
      cx       <= '0;
      cy       <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
      addr_q   <= '0;
      color_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          x0      <= bus.cmd_x;
          y0      <= bus.cmd_y;
          color_q <= bus.cmd_color;
          x_end   <= (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
          y_end   <= (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
        end
        SETUP: if (!empty) begin
          row_base <= row_base_init;
          cx       <= x0;
          cy       <= y0;
          addr_q   <= row_base_init + ADDR_W'(x0);
        end
        // The final pixel leaves the counters alone so fb_addr never steps past the screen.
        FILL: if (wr_done && !last_px) begin
          if (row_end) begin
            cx       <= x0;
            cy       <= cy + 10'd1;
            row_base <= row_base + ADDR_W'(H_RES);
            addr_q   <= row_base + ADDR_W'(H_RES) + ADDR_W'(x0);
          end else begin
            cx     <= cx + 10'd1;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.fb_we     = (state == FILL);
  assign bus.fb_addr   = addr_q;
  assign bus.fb_wdata  = color_q;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: vector table of rectangles with hand-clipped
// bounds, plus stall, busy-ignore and mid-fill reset sequences.
module tb_fb_rect_writer;

  logic Clk = 1'b0;
  logic Reset;
  logic busy, done;

  fb_rect_writer_if #(.ADDR_W(19), .COLOR_W(4)) bus ();

  fb_rect_writer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x, y, w, h, color;
    int ex0, ex_end, ey0;
    int n;
    int done_cyc;
    int poke;
  } vec_t;

  vec_t vecs [8];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input vec_t v, input bit stall_at_1);
    int n, cyc, done_cyc, first_cyc, wx, exp_addr, stall_left, hold1;
    wx = v.ex_end - v.ex0;
    bus.cmd_x     = v.x[9:0];
    bus.cmd_y     = v.y[9:0];
    bus.cmd_w     = v.w[9:0];
    bus.cmd_h     = v.h[9:0];
    bus.cmd_color = v.color[3:0];
    bus.cmd_valid = 1'b1;
    bus.fb_stall  = 1'b0;
    chk("ready_before_cmd", int'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    cyc = 1;
    chk("setup_we", int'(bus.fb_we), 0);
    chk("setup_busy", int'(busy), 1);
    n = 0; done_cyc = -1; first_cyc = -1; stall_left = 3; hold1 = 0;
    while (cyc < v.n + 60 && done_cyc < 0) begin
      tick();
      cyc++;
      bus.fb_stall  = 1'b0;
      bus.cmd_valid = 1'b0;
      if (done) begin
        done_cyc = cyc;
        chk("we_in_done", int'(bus.fb_we), 0);
      end else if (bus.fb_we) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stall_at_1 && bus.fb_addr == 19'd1) hold1++;
        if (stall_at_1 && bus.fb_addr == 19'd1 && stall_left > 0) begin
          bus.fb_stall = 1'b1;
          stall_left--;
        end else if (n >= v.n) begin
          errors++; checks++;
          $display("FAIL extra_write: addr %0d beyond expected count %0d", bus.fb_addr, v.n);
          n++;
        end else begin
          exp_addr = (v.ey0 + n / wx) * 640 + v.ex0 + n % wx;
          chk("addr", int'(bus.fb_addr), exp_addr);
          chk("wdata", int'(bus.fb_wdata), v.color);
          n++;
        end
      end
      if (cyc == v.poke) begin
        bus.cmd_x = 10'd1; bus.cmd_y = 10'd1; bus.cmd_w = 10'd1; bus.cmd_h = 10'd1;
        bus.cmd_color = 4'hA;
        bus.cmd_valid = 1'b1;
        chk("ready_while_busy", int'(bus.cmd_ready), 0);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.fb_stall  = 1'b0;
    if (done_cyc < 0) begin
      errors++; checks++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
    chk("write_count", n, v.n);
    chk("done_cycle", done_cyc, v.done_cyc);
    if (v.n > 0) chk("first_write_cycle", first_cyc, 2);
    if (stall_at_1) chk("stall_hold_cycles", hold1, 4);
    tick();
    chk("ready_after_done", int'(bus.cmd_ready), 1);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    tick();
    chk("no_queued_cmd", int'(busy), 0);
  endtask

  initial begin
    int cnt;
    vec_t sv;
    //           x    y    w    h  col ex0 ex_end ey0    n  done poke
    vecs[0] = '{ 10,   5,   2,   2, 7,  10,  12,    5,    4,    6,  0};
    vecs[1] = '{638, 479,   5,   3, 2, 638, 640,  479,    2,    4,  0};
    vecs[2] = '{  0,   0,   0,   5, 3,   0,   0,    0,    0,    2,  0};
    vecs[3] = '{700,   0,   4,   1, 5, 700, 640,    0,    0,    2,  0};
    vecs[4] = '{  0,   0,   1,   1, 15,  0,   1,    0,    1,    3,  0};
    vecs[5] = '{100, 470,   3,  20, 9, 100, 103,  470,   30,   32,  0};
    vecs[6] = '{  5, 500,   1,   1, 4,   5,   6,  500,    0,    2,  0};
    vecs[7] = '{  0,   0, 640,   2, 1,   0, 640,    0, 1280, 1282, 50};

    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.fb_stall = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_we", int'(bus.fb_we), 0);
    chk("rst_addr", int'(bus.fb_addr), 0);
    chk("rst_wdata", int'(bus.fb_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    Reset = 1'b0;
    tick();
    chk("rst_ready", int'(bus.cmd_ready), 1);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], 1'b0);

    sv = '{0, 0, 4, 1, 5, 0, 4, 0, 4, 9, 0};
    run_cmd(sv, 1'b1);

    bus.cmd_x = 10'd0; bus.cmd_y = 10'd0; bus.cmd_w = 10'd640; bus.cmd_h = 10'd2;
    bus.cmd_color = 4'd6;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 300 && cnt < 100; c++) begin
      tick();
      if (bus.fb_we && !bus.fb_stall) cnt++;
    end
    chk("writes_before_reset", cnt, 100);
    Reset = 1'b1;
    tick();
    chk("midrst_we", int'(bus.fb_we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(bus.fb_addr), 0);
    Reset = 1'b0;
    tick();
    chk("postrst_done", int'(done), 0);
    chk("postrst_ready", int'(bus.cmd_ready), 1);
    run_cmd(vecs[4], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Drawing engine that fills the 640x480, 4-bit palette-indexed frame buffer that the VGA colour path reads out.
- Accepts one "fill rectangle with colour index" command at a time through a valid/ready handshake.
- Clips the rectangle to the screen, then issues one buffer write per pixel in raster order on the buffer's write port.
- Honours a stall input so the buffer arbiter can hold off writes.

Parameters:
H_RES, 640, horizontal pixels per line and row stride of the linear buffer address
V_RES, 480, visible lines
ADDR_W, 19, width of fb_addr (must hold H_RES*V_RES-1 = 307199)
COLOR_W, 4, palette index width

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command this cycle
cmd_x  input  10  rectangle left column
cmd_y  input  10  rectangle top row
cmd_w  input  10  width in pixels
cmd_h  input  10  height in pixels
cmd_color  input  COLOR_W  palette index to write
fb_we  output  1  write request
fb_addr  output  ADDR_W  linear address, y*H_RES + x
fb_wdata  output  COLOR_W  palette index
fb_stall  input  1  write port not granted this cycle
busy  output  1  command in progress (not IDLE)
done  output  1  one-cycle pulse when a command completes

Behaviour:
- One clock domain: Clk. Reset is synchronous and active-high. Reset at any time, including mid-fill:
  - next state IDLE; all in-flight work is discarded.
  - fb_we=0, fb_addr=0, fb_wdata=0, done=0, busy=0.
  - cmd_ready=1 from the first cycle after Reset deasserts.
- States: IDLE, SETUP, FILL, DONE.
- cmd_ready = (state==IDLE). A command is accepted on an edge where cmd_valid & cmd_ready. Commands presented while busy are ignored, not queued.
- Accept (edge T), IDLE->SETUP:
  - latch x0=cmd_x, y0=cmd_y, color=cmd_color.
  - x_end = min(cmd_x+cmd_w, H_RES) and y_end = min(cmd_y+cmd_h, V_RES), both computed 11 bits wide so the sum cannot overflow.
- SETUP (cycle T+1):
  - If x0>=x_end or y0>=y_end (zero width, zero height, or fully off-screen), go to DONE with no writes.
  - Otherwise row_base <= y0*H_RES (ADDR_W bits), cx <= x0, cy <= y0, then go to FILL.
- FILL:
  - fb_we=1, fb_addr=row_base+cx, fb_wdata=color. First write request appears at cycle T+2.
  - A write completes on an edge with fb_we & ~fb_stall.
  - While fb_stall=1: fb_addr, fb_wdata and all counters hold, with no skipped or duplicated addresses.
  - On a completed write: if cx==x_end-1 then cx<=x0, cy<=cy+1, row_base<=row_base+H_RES; otherwise cx<=cx+1.
  - The completed write at cx==x_end-1 and cy==y_end-1 moves to DONE; fb_we=0 from the next cycle.
- Totals: exactly (x_end-x0)*(y_end-y0) completed writes per command, in strictly raster order. fb_addr never exceeds H_RES*V_RES-1.
- DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=1 the cycle after done.
- Outputs are registered. fb_we is never high outside FILL.
- busy = (state!=IDLE), including the DONE cycle.

Test Plan:
- Rectangle x=10, y=5, w=2, h=2, color=7, no stall -> writes to 3210, 3211, 3850, 3851 on cycles T+2..T+5 with fb_wdata=7; done at T+6; cmd_ready at T+7.
- Clipping: x=638, y=479, w=5, h=3, color=2 -> exactly two writes, 307198 then 307199; done the cycle after.
- Zero-size and off-screen commands: w=0, and separately x=700 with w=4 -> no fb_we at any point; done at T+2.
- Stall: 4x1 rectangle at (0,0) with fb_stall held high for 3 cycles while fb_addr=1 -> fb_addr stays 1 for 4 cycles; completed addresses are exactly 0, 1, 2, 3.
- Full-screen clear: x=0, y=0, w=640, h=480, color=0 -> 307200 completed writes, addresses 0..307199 in order; cmd_valid pulsed mid-fill is ignored with cmd_ready=0.
- Reset asserted mid-fill (e.g. at the 100th write) -> next cycle fb_we=0, busy=0, no done pulse; a new 1x1 command at (0,0) then writes address 0 normally.
